// File: rtl/soc_mem_arb_pkg.sv
// Shared definitions for the SoC data-RAM arbiter.
//   arb_state_e : arbiter FSM states (IDLE, read-return for CPU, read-return for VGA)
//   RAM_LAT     : RAM read latency in cycles
package soc_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_RD_CPU = 2'd1,
    ARB_RD_VGA = 2'd2
  } arb_state_e;

  localparam int unsigned RAM_LAT = 1;

endpackage

// File: rtl/dfflr.sv
// Generic load-enabled flop bank with asynchronous active-low reset to zero.
//   clk   : clock
//   rst_n : asynchronous reset, active low
//   lden  : load enable
//   dnxt  : next value
//   qout  : registered value
module dfflr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/soc_arb_pick.sv
// Combinational two-way priority pick.
//   hi_req   : request from the normally-favoured requester
//   lo_req   : request from the normally-deferred requester
//   force_lo : lets lo_req win over hi_req this cycle
//   hi_gnt   : grant to the high-priority requester
//   lo_gnt   : grant to the low-priority requester
// At most one grant is ever asserted.
module soc_arb_pick (
  input  logic hi_req,
  input  logic lo_req,
  input  logic force_lo,
  output logic hi_gnt,
  output logic lo_gnt
);

  always_comb begin
    lo_gnt = lo_req & (~hi_req | force_lo);
    hi_gnt = hi_req & ~lo_gnt;
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Shares the single-port SoC data RAM between the CPU data port (read/write)
// and the VGA framebuffer fetch engine (read-only). VGA has fixed priority,
// one transaction is in flight at a time and RAM read data returns one cycle
// after a read enable. Grants are combinational from request and state.
//
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/wmask   : CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata: CPU grant and read return
//   vga_req/addr                  : VGA word-address read request
//   vga_gnt, vga_rvalid, vga_rdata: VGA grant and read return
//   ram_en/we/addr/wdata          : RAM control (owned solely by this block)
//   ram_rdata                     : RAM read data, one cycle after read enable
//
// Build option: define SOC_MEM_ARB_STARVE_GUARD_EN to let the CPU win once
// after STARVE_MAX consecutive VGA grants taken while the CPU was waiting.
module soc_mem_arbiter
  import soc_mem_arb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned VGA_AW     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic [XLEN-1:0]   cpu_wdata,
  input  logic [3:0]        cpu_wmask,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [XLEN-1:0]   cpu_rdata,
  input  logic              vga_req,
  input  logic [VGA_AW-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [XLEN-1:0]   vga_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [XLEN-1:0]   ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata
);

  if (RAM_LAT != 1 || STARVE_MAX == 0 || XLEN < VGA_AW + 2) begin : g_cfg_check
    $error("soc_mem_arbiter: unsupported RAM_LAT, STARVE_MAX or XLEN/VGA_AW");
  end

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [1:0]      state_q;
  logic            force_cpu;
  logic [XLEN-1:0] cpu_rdata_hold;
  logic [XLEN-1:0] vga_rdata_hold;

  // ---------------- state register ----------------
  dfflr #(.DW(2)) u_state_reg (
    .clk   (clk),
    .rst_n (reset),
    .lden  (1'b1),
    .dnxt  (state_nxt),
    .qout  (state_q)
  );

  always_comb state = arb_state_e'(state_q);

  // ---------------- arbitration ----------------
  soc_arb_pick u_pick (
    .hi_req   (vga_req),
    .lo_req   (cpu_req),
    .force_lo (force_cpu),
    .hi_gnt   (vga_gnt),
    .lo_gnt   (cpu_gnt)
  );

`ifdef SOC_MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             starve_ld;

  // Counts VGA wins taken over a waiting CPU; saturates so the force stays
  // armed until the CPU is actually granted.
  always_comb begin
    starve_ld  = 1'b0;
    starve_nxt = starve_cnt;
    if (cpu_gnt) begin
      starve_ld  = 1'b1;
      starve_nxt = '0;
    end else if (vga_gnt && cpu_req && (starve_cnt < CNT_W'(STARVE_MAX))) begin
      starve_ld  = 1'b1;
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  dfflr #(.DW(CNT_W)) u_starve_reg (
    .clk   (clk),
    .rst_n (reset),
    .lden  (starve_ld),
    .dnxt  (starve_nxt),
    .qout  (starve_cnt)
  );

  always_comb force_cpu = (starve_cnt >= CNT_W'(STARVE_MAX));
`else
  always_comb force_cpu = 1'b0;
`endif

  // ---------------- next-state ----------------
  // Every state re-arbitrates, so a new read can issue in a read-return cycle.
  always_comb begin
    state_nxt = ARB_IDLE;
    if (vga_gnt) begin
      state_nxt = ARB_RD_VGA;
    end else if (cpu_gnt && !cpu_we) begin
      state_nxt = ARB_RD_CPU;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (vga_gnt) begin
      ram_en   = 1'b1;
      ram_addr = {{(XLEN-VGA_AW-2){1'b0}}, vga_addr, 2'b00};
    end else if (cpu_gnt) begin
      ram_en    = 1'b1;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we ? cpu_wmask : 4'b0000;
    end

    cpu_rvalid = (state == ARB_RD_CPU);
    vga_rvalid = (state == ARB_RD_VGA);
    cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_hold;
    vga_rdata  = vga_rvalid ? ram_rdata : vga_rdata_hold;
  end

  // Returned data is captured so rdata holds once rvalid drops.
  dfflr #(.DW(XLEN)) u_cpu_hold (
    .clk   (clk),
    .rst_n (reset),
    .lden  (cpu_rvalid),
    .dnxt  (ram_rdata),
    .qout  (cpu_rdata_hold)
  );

  dfflr #(.DW(XLEN)) u_vga_hold (
    .clk   (clk),
    .rst_n (reset),
    .lden  (vga_rvalid),
    .dnxt  (ram_rdata),
    .qout  (vga_rdata_hold)
  );

endmodule
